// File: rtl/uc_puzzle_matriz.sv
// -----------------------------------------------------------------------------
// uc_puzzle_matriz
//
// Control unit for a button-matrix puzzle game. It debounces nothing; it only
// synchronises the raw start and puzzle buttons into clk, turns each rising
// edge into one pulse, and runs the level sequencing FSM:
//
//   IDLE -> LIMPA -> ASSENTA -> JOGA <-> AGUARDA
//                                 |
//                                 v
//                              CONCLUI -> LIMPA (next level) or VITORIA
//
// LIMPA clears the matrix driver, ASSENTA/AGUARDA give the driver two cycles
// to settle after a clear or a move, JOGA forwards button presses as toggle
// pulses, CONCLUI pauses after a solved level.
//
// Optional feature (macro UC_TIMEOUT_EN): a per-level timeout counter running
// in JOGA/AGUARDA that sends the FSM to DERROTA. Without the macro there is no
// counter and derrota is tied low.
//
// Parameters:
//   TIMEOUT_CICLOS  cycles allowed in JOGA/AGUARDA per level (timeout build)
//   PAUSA_CICLOS    cycles spent in CONCLUI before moving on
//   NIVEL_MAX       index of the last level
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   iniciar          raw start button (asynchronous)
//   botoes_in[7:0]   raw puzzle buttons (asynchronous)
//   nivel_concluido  registered "level solved" flag from the matrix driver
//   botoes_out[7:0]  one-cycle toggle pulses to the matrix driver
//   nivel[2:0]       current level index
//   rst_matriz       one-cycle clear pulse to the matrix driver
//   jogando          high in ASSENTA, JOGA, AGUARDA
//   vitoria          high in VITORIA
//   derrota          high in DERROTA
//   jogadas[7:0]     moves made in the current level (saturating)
//   db_estado[2:0]   current state encoding, for debug
// -----------------------------------------------------------------------------
module uc_puzzle_matriz #(
    parameter logic [31:0] TIMEOUT_CICLOS = 32'd50_000_000,
    parameter logic [31:0] PAUSA_CICLOS   = 32'd25_000_000,
    parameter logic [2:0]  NIVEL_MAX      = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    input  logic [7:0] botoes_in,
    input  logic       nivel_concluido,
    output logic [7:0] botoes_out,
    output logic [2:0] nivel,
    output logic       rst_matriz,
    output logic       jogando,
    output logic       vitoria,
    output logic       derrota,
    output logic [7:0] jogadas,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LIMPA   = 3'd1,
        ASSENTA = 3'd2,
        JOGA    = 3'd3,
        AGUARDA = 3'd4,
        CONCLUI = 3'd5,
        VITORIA = 3'd6,
        DERROTA = 3'd7
    } estado_t;

    // Last count value of the two-cycle settle states (count runs 0, 1).
    localparam logic [31:0] ESPERA_FIM = 32'd1;

    estado_t     estado_reg, estado_next;
    logic [2:0]  nivel_reg, nivel_next;
    logic [7:0]  jogadas_reg, jogadas_next;
    logic [7:0]  botoes_out_reg, botoes_out_next;
    logic [31:0] cnt_reg, cnt_next;

    // -------------------------------------------------------------------------
    // Input synchronisers and rising-edge detectors.
    // Bit 8 is iniciar, bits 7:0 are the puzzle buttons.
    // -------------------------------------------------------------------------
    logic [8:0] entrada_raw;
    logic [8:0] borda;
    logic       ini_borda;
    logic [7:0] btn_borda;

    assign entrada_raw = {iniciar, botoes_in};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            logic ant_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    ant_reg <= 1'b0;
                end else begin
                    s1_reg  <= entrada_raw[gi];
                    s2_reg  <= s1_reg;
                    ant_reg <= s2_reg;
                end
            end

            assign borda[gi] = s2_reg & ~ant_reg;
        end
    endgenerate

    assign ini_borda = borda[8];
    assign btn_borda = borda[7:0];

    // -------------------------------------------------------------------------
    // Optional per-level timeout.
    // -------------------------------------------------------------------------
    logic estouro;

`ifdef UC_TIMEOUT_EN
    logic [31:0] tmo_reg, tmo_next;

    assign estouro = (tmo_reg == TIMEOUT_CICLOS - 32'd1);

    always_comb begin
        tmo_next = tmo_reg;
        if (estado_reg == LIMPA) begin
            tmo_next = '0;
        end else if (estado_reg == JOGA || estado_reg == AGUARDA) begin
            tmo_next = tmo_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_reg <= '0;
        end else begin
            tmo_reg <= tmo_next;
        end
    end

    assign derrota = (estado_reg == DERROTA);
`else
    // No timeout hardware: DERROTA can never be entered.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CICLOS;
    assign estouro        = 1'b0;
    assign derrota        = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic.
    // -------------------------------------------------------------------------
    always_comb begin
        estado_next     = estado_reg;
        nivel_next      = nivel_reg;
        jogadas_next    = jogadas_reg;
        cnt_next        = '0;
        botoes_out_next = '0;

        case (estado_reg)
            IDLE: begin
                if (ini_borda) begin
                    nivel_next  = '0;
                    estado_next = LIMPA;
                end
            end

            LIMPA: begin
                jogadas_next = '0;
                estado_next  = ASSENTA;
            end

            ASSENTA: begin
                if (cnt_reg == ESPERA_FIM) begin
                    estado_next = JOGA;
                end
            end

            JOGA: begin
                // Priority: restart, timeout, move, level solved.
                if (ini_borda) begin
                    estado_next = LIMPA;
                end else if (estouro) begin
                    estado_next = DERROTA;
                end else if (botoes_out_reg != 8'h00) begin
                    if (jogadas_reg != 8'hFF) begin
                        jogadas_next = jogadas_reg + 8'd1;
                    end
                    estado_next = AGUARDA;
                end else if (nivel_concluido) begin
                    estado_next = CONCLUI;
                end
            end

            AGUARDA: begin
                if (ini_borda) begin
                    estado_next = LIMPA;
                end else if (estouro) begin
                    estado_next = DERROTA;
                end else if (cnt_reg == ESPERA_FIM) begin
                    estado_next = JOGA;
                end
            end

            CONCLUI: begin
                if (ini_borda) begin
                    estado_next = LIMPA;
                end else if (cnt_reg == PAUSA_CICLOS - 32'd1) begin
                    if (nivel_reg == NIVEL_MAX) begin
                        estado_next = VITORIA;
                    end else begin
                        nivel_next  = nivel_reg + 3'd1;
                        estado_next = LIMPA;
                    end
                end
            end

            VITORIA, DERROTA: begin
                if (ini_borda) begin
                    nivel_next  = '0;
                    estado_next = LIMPA;
                end
            end

            default: begin
                estado_next = IDLE;
            end
        endcase

        // Dwell counter: only the timed states count, and every state change
        // restarts it so each timed state sees a fresh count from zero.
        if (estado_next == estado_reg &&
            (estado_reg == ASSENTA || estado_reg == AGUARDA || estado_reg == CONCLUI)) begin
            cnt_next = cnt_reg + 32'd1;
        end

        // A button pulse is only forwarded when the FSM stays in JOGA, so the
        // registered pulse can never appear in any other state. This also
        // drops buttons that coincide with a start edge or with the move cycle.
        if (estado_reg == JOGA && estado_next == JOGA) begin
            botoes_out_next = btn_borda;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_reg     <= IDLE;
            nivel_reg      <= '0;
            jogadas_reg    <= '0;
            botoes_out_reg <= '0;
            cnt_reg        <= '0;
        end else begin
            estado_reg     <= estado_next;
            nivel_reg      <= nivel_next;
            jogadas_reg    <= jogadas_next;
            botoes_out_reg <= botoes_out_next;
            cnt_reg        <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign botoes_out = botoes_out_reg;
    assign nivel      = nivel_reg;
    assign jogadas    = jogadas_reg;
    assign rst_matriz = (estado_reg == LIMPA);
    assign jogando    = (estado_reg == ASSENTA) || (estado_reg == JOGA) ||
                        (estado_reg == AGUARDA);
    assign vitoria    = (estado_reg == VITORIA);
    assign db_estado  = estado_reg;

endmodule

// File: tb/tb_uc_puzzle_matriz.sv
// -----------------------------------------------------------------------------
// Testbench for uc_puzzle_matriz: a directed vector table from reset through
// two moves and a solved level, hand-written sequences for the win, restart,
// timeout and reset-during-pause cases, then randomized stimulus checked
// against a cycle-level game model.
// -----------------------------------------------------------------------------
module tb_uc_puzzle_matriz;

    localparam logic [31:0] TMO   = 32'd16;
    localparam logic [31:0] PAUSA = 32'd4;
    localparam logic [2:0]  NMAX  = 3'd4;
`ifdef UC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iniciar = 1'b0;
    logic [7:0] botoes_in = 8'h00;
    logic       conc = 1'b0;
    logic [7:0] botoes_out;
    logic [2:0] nivel;
    logic       rst_matriz, jogando, vitoria, derrota;
    logic [7:0] jogadas;
    logic [2:0] db_estado;

    always #5 clk = ~clk;

    uc_puzzle_matriz #(
        .TIMEOUT_CICLOS(TMO),
        .PAUSA_CICLOS  (PAUSA),
        .NIVEL_MAX     (NMAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .iniciar        (iniciar),
        .botoes_in      (botoes_in),
        .nivel_concluido(conc),
        .botoes_out     (botoes_out),
        .nivel          (nivel),
        .rst_matriz     (rst_matriz),
        .jogando        (jogando),
        .vitoria        (vitoria),
        .derrota        (derrota),
        .jogadas        (jogadas),
        .db_estado      (db_estado)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%07h required=%07h", nome, act, exp);
        end
    endtask

    // Packed view {db_estado, nivel, botoes_out, jogadas, rst_matriz, jogando, vitoria, derrota}
    function automatic logic [25:0] dut_pack();
        return {db_estado, nivel, botoes_out, jogadas, rst_matriz, jogando, vitoria, derrota};
    endfunction

    function automatic logic [25:0] exp_pack(input logic [2:0] st, input logic [2:0] niv,
                                             input logic [7:0] bo, input logic [7:0] jog);
        logic rm, jg, vi, de;
        rm = (st == 3'd1);
        jg = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        vi = (st == 3'd6);
        de = (st == 3'd7);
        return {st, niv, bo, jog, rm, jg, vi, de};
    endfunction

    // -------------------------------------------------------------------------
    // Behavioural game model (phases with countdowns, input history for the
    // two-cycle synchroniser delay).
    // -------------------------------------------------------------------------
    typedef enum int {M_IDLE, M_CLEAR, M_SETTLE, M_PLAY, M_WAITMV, M_PAUSE, M_WIN, M_LOSE} mode_t;

    mode_t      m_mode;
    int         m_left, m_used;
    logic [2:0] m_level;
    logic [7:0] m_moves, m_pulse;
    logic       h_ini [3];
    logic [7:0] h_btn [3];

    function automatic logic [2:0] enc(input mode_t m);
        case (m)
            M_IDLE:   return 3'd0;
            M_CLEAR:  return 3'd1;
            M_SETTLE: return 3'd2;
            M_PLAY:   return 3'd3;
            M_WAITMV: return 3'd4;
            M_PAUSE:  return 3'd5;
            M_WIN:    return 3'd6;
            default:  return 3'd7;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_used = 0;
        m_level = 3'd0; m_moves = 8'h00; m_pulse = 8'h00;
        for (int k = 0; k < 3; k++) begin
            h_ini[k] = 1'b0;
            h_btn[k] = 8'h00;
        end
    endtask

    task automatic model_step();
        logic       ini_e;
        logic [7:0] btn_e;
        mode_t      nm;
        logic       lose;
        ini_e = h_ini[1] & ~h_ini[2];
        btn_e = h_btn[1] & ~h_btn[2];
        nm    = m_mode;
        lose  = TMO_ON && (m_used == int'(TMO) - 1);
        case (m_mode)
            M_IDLE: if (ini_e) begin nm = M_CLEAR; m_level = 3'd0; end
            M_CLEAR: begin m_moves = 8'h00; m_used = 0; nm = M_SETTLE; m_left = 2; end
            M_SETTLE: begin m_left--; if (m_left == 0) nm = M_PLAY; end
            M_PLAY: begin
                if (ini_e) nm = M_CLEAR;
                else if (lose) nm = M_LOSE;
                else if (m_pulse != 8'h00) begin
                    if (m_moves != 8'hFF) m_moves++;
                    nm = M_WAITMV; m_left = 2;
                end else if (conc) begin
                    nm = M_PAUSE; m_left = int'(PAUSA);
                end
                m_used++;
            end
            M_WAITMV: begin
                if (ini_e) nm = M_CLEAR;
                else if (lose) nm = M_LOSE;
                else begin m_left--; if (m_left == 0) nm = M_PLAY; end
                m_used++;
            end
            M_PAUSE: begin
                if (ini_e) nm = M_CLEAR;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_level == NMAX) nm = M_WIN;
                        else begin m_level++; nm = M_CLEAR; end
                    end
                end
            end
            default: if (ini_e) begin nm = M_CLEAR; m_level = 3'd0; end
        endcase
        m_pulse = (m_mode == M_PLAY && nm == M_PLAY) ? btn_e : 8'h00;
        m_mode  = nm;
        h_ini[2] = h_ini[1]; h_ini[1] = h_ini[0]; h_ini[0] = iniciar;
        h_btn[2] = h_btn[1]; h_btn[1] = h_btn[0]; h_btn[0] = botoes_in;
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic       ini;
        logic [7:0] btn;
        logic       c;
        logic [2:0] st;
        logic [2:0] niv;
        logic [7:0] bo;
        logic [7:0] jog;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    task automatic tv(input int i, input logic ini, input logic [7:0] btn, input logic c,
                      input logic [2:0] st, input logic [2:0] niv, input logic [7:0] bo,
                      input logic [7:0] jog);
        tbl[i] = '{ini: ini, btn: btn, c: c, st: st, niv: niv, bo: bo, jog: jog};
    endtask

    task automatic wait_state(input logic [2:0] st, input int limite, input string nome);
        bit achou;
        achou = 1'b0;
        for (int k = 0; k < limite; k++) begin
            if (db_estado == st) begin
                achou = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(nome, 32'(achou), 32'd1);
    endtask

    task automatic press_ini(input logic [2:0] niv_esp);
        iniciar = 1'b1;
        repeat (2) @(negedge clk);
        iniciar = 1'b0;
        wait_state(3'd1, 10, "ini_to_limpa");
        check("ini_nivel", 32'(nivel), 32'(niv_esp));
        $display("restart: state=%0d nivel=%0d", db_estado, nivel);
    endtask

    task automatic win_level(input logic [2:0] lvl);
        int n;
        wait_state(3'd3, 20, "lvl_reach_joga");
        check("lvl_nivel", 32'(nivel), 32'(lvl));
        conc = 1'b1;
        @(negedge clk);
        conc = 1'b0;
        check("lvl_conclui", 32'(db_estado), 32'd5);
        n = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (db_estado == 3'd5) n++;
            else break;
        end
        check("lvl_pause_len", 32'(n), PAUSA);
        if (lvl == NMAX) check("lvl_vitoria", 32'(dut_pack()), 32'(exp_pack(3'd6, NMAX, 8'h00, 8'h00)));
        else check("lvl_next", 32'(dut_pack()), 32'(exp_pack(3'd1, lvl + 3'd1, 8'h00, 8'h00)));
        $display("level %0d done: state=%0d nivel=%0d pause=%0d", lvl, db_estado, nivel, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Table: reset release, start, single held button, two-bit press, solved level.
        tv(0, 1, 8'h00, 0, 3'd0, 3'd0, 8'h00, 8'd0);
        tv(1, 1, 8'h00, 0, 3'd0, 3'd0, 8'h00, 8'd0);
        tv(2, 0, 8'h00, 0, 3'd1, 3'd0, 8'h00, 8'd0);
        tv(3, 0, 8'h00, 0, 3'd2, 3'd0, 8'h00, 8'd0);
        tv(4, 0, 8'h00, 0, 3'd2, 3'd0, 8'h00, 8'd0);
        tv(5, 0, 8'h00, 0, 3'd3, 3'd0, 8'h00, 8'd0);
        tv(6, 0, 8'h01, 0, 3'd3, 3'd0, 8'h00, 8'd0);
        tv(7, 0, 8'h01, 0, 3'd3, 3'd0, 8'h00, 8'd0);
        tv(8, 0, 8'h01, 0, 3'd3, 3'd0, 8'h01, 8'd0);
        tv(9, 0, 8'h01, 0, 3'd4, 3'd0, 8'h00, 8'd1);
        tv(10, 0, 8'h01, 0, 3'd4, 3'd0, 8'h00, 8'd1);
        for (int i = 11; i < 16; i++) tv(i, 0, 8'h01, 0, 3'd3, 3'd0, 8'h00, 8'd1);
        tv(16, 0, 8'h00, 0, 3'd3, 3'd0, 8'h00, 8'd1);
        tv(17, 0, 8'h81, 0, 3'd3, 3'd0, 8'h00, 8'd1);
        tv(18, 0, 8'h81, 0, 3'd3, 3'd0, 8'h00, 8'd1);
        tv(19, 0, 8'h81, 0, 3'd3, 3'd0, 8'h81, 8'd1);
        tv(20, 0, 8'h81, 0, 3'd4, 3'd0, 8'h00, 8'd2);
        tv(21, 0, 8'h81, 0, 3'd4, 3'd0, 8'h00, 8'd2);
        tv(22, 0, 8'h00, 0, 3'd3, 3'd0, 8'h00, 8'd2);
        tv(23, 0, 8'h00, 1, 3'd5, 3'd0, 8'h00, 8'd2);
        tv(24, 0, 8'h00, 0, 3'd5, 3'd0, 8'h00, 8'd2);
        tv(25, 0, 8'h00, 0, 3'd5, 3'd0, 8'h00, 8'd2);
        tv(26, 0, 8'h00, 0, 3'd5, 3'd0, 8'h00, 8'd2);
        tv(27, 0, 8'h00, 0, 3'd1, 3'd1, 8'h00, 8'd2);
`ifdef UC_TIMEOUT_EN
        // 16th cycle in JOGA/AGUARDA lands on row 21: defeat, win flag ignored.
        for (int i = 21; i < NVEC; i++) tv(i, 0, tbl[i].btn, tbl[i].c, 3'd7, 3'd0, 8'h00, 8'd2);
`endif

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dut_pack()), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            iniciar   = tbl[i].ini;
            botoes_in = tbl[i].btn;
            conc      = tbl[i].c;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(dut_pack()),
                  32'(exp_pack(tbl[i].st, tbl[i].niv, tbl[i].bo, tbl[i].jog)));
            $display("vec %0d: ini=%0d btn=%02h conc=%0d -> state=%0d nivel=%0d bo=%02h jog=%0d",
                     i, tbl[i].ini, tbl[i].btn, tbl[i].c, db_estado, nivel, botoes_out, jogadas);
        end

        // Run the remaining levels to victory.
        if (TMO_ON) begin
            press_ini(3'd0);
            for (int l = 0; l <= int'(NMAX); l++) win_level(3'(l));
        end else begin
            for (int l = 1; l <= int'(NMAX); l++) win_level(3'(l));
        end

        // New game, then reset pulled low in CONCLUI.
        press_ini(3'd0);
        wait_state(3'd3, 20, "rstc_reach_joga");
        conc = 1'b1;
        @(negedge clk);
        conc = 1'b0;
        check("rstc_conclui", 32'(db_estado), 32'd5);
        #2 rst = 1'b0;
        #1 check("rstc_async", 32'(dut_pack()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstc_hold", 32'(dut_pack()), 32'd0);
        end
        $display("reset in CONCLUI: state=%0d rst_matriz=%0d", db_estado, rst_matriz);

        // Randomized run against the model.
        iniciar = 1'b0; botoes_in = 8'h00; conc = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rand", 32'(dut_pack()),
                  32'(exp_pack(enc(m_mode), m_level, m_pulse, m_moves)));
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                model_reset();
                #1 check("rand_rst_async", 32'(dut_pack()), 32'd0);
            end else begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 99) < 3) iniciar = ~iniciar;
            if ($urandom_range(0, 9) < 2) botoes_in = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            conc = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            if (rst) model_step();
            @(negedge clk);
        end
        $display("random run: state=%0d nivel=%0d jogadas=%0d", db_estado, nivel, jogadas);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
